kbd_event_decoder: RTL
======================

# kbd_event_decoder

Parametrised PS/2 scancode front-end that sits between `ps2_keyboard` and the display/ASCII path. Pops bytes from the keyboard receiver and parses `E0` (extended) and `F0` (break) prefixes into complete make/break key events. Events are buffered in a configurable FIFO, and the block tracks the currently held key and a keypress counter for the 7-segment displays.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, at least 2.
- `CNT_WIDTH`, 8: width of the keypress counter and the drop counter.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset.
- `ps2_data` in 8: byte presented by `ps2_keyboard`.
- `ps2_ready` in 1: a byte is available on `ps2_data`.
- `ps2_overflow` in 1: the receiver's internal queue overflowed.
- `ps2_nextdata_n` out 1: active-low one-cycle pop strobe to `ps2_keyboard`.
- `ev_valid` out 1: FIFO head is valid.
- `ev_ready` in 1: the consumer accepts the head this cycle.
- `ev_data` out 10: FIFO head, formatted `{ext, brk, code[7:0]}`.
- `held_valid` out 1: a key is currently held.
- `held_code` out 9: `{ext, code}` of the held key.
- `press_cnt` out CNT_WIDTH: number of accepted make events; wraps.
- `drop_cnt` out CNT_WIDTH: events lost to a full FIFO; saturates.
- `ovf_sticky` out 1: latched `ps2_overflow`.

## Operation
- Reset values of all outputs: `ps2_nextdata_n`=1, `ev_valid`=0, `ev_data`=0, `held_valid`=0, `held_code`=0, `press_cnt`=0, `drop_cnt`=0, `ovf_sticky`=0.
- Reset also clears the FIFO pointers and occupancy and returns both FSMs to their initial states.

Fetch FSM:
- `FETCH`: if `ps2_ready`=1, drive `ps2_nextdata_n`=0 this cycle, latch `ps2_data`, go to `GAP`.
- `GAP`: hold `ps2_nextdata_n`=1 for one cycle, then return to `FETCH`. This prevents a double pop while the receiver updates `ps2_ready`.

Parse FSM, running one cycle after a latch:
- `BASE`: `E0` → `EXT`; `F0` → `BRK`; any other byte emits a make event with ext=0 and stays in `BASE`.
- `EXT`: `F0` → `EXTBRK`; `E0` → stay in `EXT`; other bytes emit a make event with ext=1 → `BASE`.
- `BRK`: any byte except `E0`/`F0` emits a break event with ext=0 → `BASE`. A prefix byte received here is malformed: discard it and go to `BASE`.
- `EXTBRK`: emits a break event with ext=1 → `BASE`. Prefix bytes are handled as in `BRK`.

Event handling:
- Make event: increment `press_cnt` (mod 2^CNT_WIDTH). Set `held_valid`=1 and `held_code`={ext, code}.
- Break event: if {ext, code} equals `held_code`, clear `held_valid`; `held_code` keeps its value. A break for any other key leaves the held state unchanged.
- Every emitted event is pushed to the FIFO. If the FIFO is full and not popping this cycle, the event is dropped and `drop_cnt` increments, saturating at all-ones.
- Held-state and `press_cnt` updates happen even when the event is dropped.
- FIFO pop occurs when `ev_valid`=1 and `ev_ready`=1.
- Simultaneous push and pop when full: both happen, no drop.
- Simultaneous push and pop when empty: the push lands and `ev_valid` rises next cycle.
- `ovf_sticky` is set by `ps2_overflow`=1 and cleared only by reset.

## Timing
- Cycle T: `ps2_ready`=1 is sampled in `FETCH`; `ps2_nextdata_n`=0 during T; the byte is latched at the end of T.
- T+1: parse step; FIFO write, counter update and held-state update all occur at the end of T+1.
- T+2: `ev_valid`=1, `press_cnt` and `held_*` reflect the byte.
- Maximum throughput is one byte per 2 cycles.
- `ev_data` is a registered FIFO head and is stable while `ev_valid`=1 and `ev_ready`=0.
- Reset asserted mid-sequence (prefix pending or `GAP`) abandons the sequence. The first cycle after reset deassertion is `FETCH`/`BASE`.

## Configuration
- `KBD_TYPEMATIC_FILTER_EN` defined:
  - A make event whose {ext, code} equals `held_code` while `held_valid`=1 is a typematic repeat.
  - A repeat is neither pushed nor counted in `press_cnt`.
- Not defined: every make event is pushed and counted.

## Test plan
- Bytes `1C`, `F0`, `1C`:
  - Events `0x01C` then `0x11C`.
  - `press_cnt`=1.
  - `held_valid` goes 1 then 0.
  - `ps2_nextdata_n` pulses low exactly 3 times, one cycle each.
- Bytes `E0 75`, `E0 F0 75`:
  - Events `0x275` then `0x375`.
  - `held_code`=`0x175` while held.
- Bytes `1B 1B 1B F0 1B`:
  - Without the macro: 4 events and `press_cnt`=3.
  - With `KBD_TYPEMATIC_FILTER_EN`: 2 events (`0x01B`, `0x11B`) and `press_cnt`=1.
- `ev_ready`=0 with FIFO_DEPTH=4 and 6 make codes:
  - FIFO holds the first 4 events and `drop_cnt`=2.
  - Then `ev_ready`=1 drains them in order.
- Full FIFO with `ev_ready`=1 while a new event arrives: no drop, occupancy stays 4.
- `reset` asserted after `E0`, then byte `75`: make event `0x075` (ext=0), `ovf_sticky`=0.
- `ps2_overflow` pulses for 1 cycle: `ovf_sticky`=1 until reset.

Source files
------------

// File: rtl/kbd_event_decoder.sv
// PS/2 scancode front-end: pops bytes from ps2_keyboard, folds E0/F0
// prefixes into make/break events, buffers them in a FIFO and tracks
// the held key, a keypress counter and a drop counter.
//
// Ports:
//   clock, reset      : clock and synchronous active-high reset
//   ps2_data/ready    : byte and byte-available flag from the receiver
//   ps2_overflow      : receiver queue overflow flag (latched)
//   ps2_nextdata_n    : active-low one-cycle pop strobe to the receiver
//   ev_valid/ready    : event FIFO head handshake
//   ev_data           : {ext, brk, code[7:0]} at the FIFO head
//   held_valid/code   : currently held key {ext, code}
//   press_cnt         : accepted make events (wraps)
//   drop_cnt          : events lost to a full FIFO (saturates)
//   ovf_sticky        : latched ps2_overflow
//
// Build option: KBD_TYPEMATIC_FILTER_EN suppresses typematic repeats
// (make of the already held key) from the FIFO and press_cnt.
module kbd_event_decoder #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [7:0]           ps2_data,
   input  logic                 ps2_ready,
   input  logic                 ps2_overflow,
   output logic                 ps2_nextdata_n,
   output logic                 ev_valid,
   input  logic                 ev_ready,
   output logic [9:0]           ev_data,
   output logic                 held_valid,
   output logic [8:0]           held_code,
   output logic [CNT_WIDTH-1:0] press_cnt,
   output logic [CNT_WIDTH-1:0] drop_cnt,
   output logic                 ovf_sticky
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic {F_FETCH, F_GAP} fetch_t;
   typedef enum logic [1:0] {P_BASE, P_EXT, P_BRK, P_EXTBRK} parse_t;

   fetch_t r_fstate, w_fnext;
   parse_t r_pstate, w_pnext;

   logic       w_pop;
   logic [7:0] r_byte;
   logic       r_byte_vld;
   logic       w_is_e0, w_is_f0;
   logic       w_emit, w_ext, w_brk;
   logic       w_repeat, w_push_req;

   logic [9:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_full, w_fifo_pop, w_push, w_drop;

   logic          r_held_valid;
   logic [8:0]    r_held_code;
   logic [CNT_WIDTH-1:0] r_press_cnt, r_drop_cnt;
   logic          r_ovf;

   // ---------------- fetch FSM ----------------
   always_ff @(posedge clock) begin
      if (reset) r_fstate <= F_FETCH;
      else       r_fstate <= w_fnext;
   end

   always_comb begin
      w_fnext = r_fstate;
      case (r_fstate)
         F_FETCH: if (ps2_ready) w_fnext = F_GAP;
         F_GAP:   w_fnext = F_FETCH;
         default: w_fnext = F_FETCH;
      endcase
   end

   // Strobe is gated by reset so the receiver is never popped during reset.
   always_comb begin
      w_pop          = (r_fstate == F_FETCH) & ps2_ready & ~reset;
      ps2_nextdata_n = ~w_pop;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_byte     <= 8'h00;
         r_byte_vld <= 1'b0;
      end else begin
         r_byte_vld <= w_pop;
         if (w_pop) r_byte <= ps2_data;
      end
   end

   // ---------------- parse FSM ----------------
   assign w_is_e0 = (r_byte == 8'hE0);
   assign w_is_f0 = (r_byte == 8'hF0);

   always_ff @(posedge clock) begin
      if (reset) r_pstate <= P_BASE;
      else       r_pstate <= w_pnext;
   end

   always_comb begin
      w_pnext = r_pstate;
      if (r_byte_vld) begin
         case (r_pstate)
            P_BASE: begin
               if (w_is_e0)      w_pnext = P_EXT;
               else if (w_is_f0) w_pnext = P_BRK;
            end
            P_EXT: begin
               if (w_is_f0)       w_pnext = P_EXTBRK;
               else if (!w_is_e0) w_pnext = P_BASE;
            end
            // Malformed prefix after F0 is dropped along with the sequence.
            default: w_pnext = P_BASE;
         endcase
      end
   end

   always_comb begin
      w_emit = 1'b0;
      w_ext  = 1'b0;
      w_brk  = 1'b0;
      if (r_byte_vld && !w_is_e0 && !w_is_f0) begin
         w_emit = 1'b1;
         case (r_pstate)
            P_EXT:    w_ext = 1'b1;
            P_BRK:    w_brk = 1'b1;
            P_EXTBRK: begin w_ext = 1'b1; w_brk = 1'b1; end
            default:  ;
         endcase
      end
   end

`ifdef KBD_TYPEMATIC_FILTER_EN
   assign w_repeat = w_emit & ~w_brk & r_held_valid &
                     ({w_ext, r_byte} == r_held_code);
`else
   assign w_repeat = 1'b0;
`endif

   assign w_push_req = w_emit & ~w_repeat;

   // ---------------- event FIFO ----------------
   assign w_full     = (r_count == DEPTH_C);
   assign w_fifo_pop = ev_valid & ev_ready;
   assign w_push     = w_push_req & (~w_full | w_fifo_pop);
   assign w_drop     = w_push_req & w_full & ~w_fifo_pop;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 10'd0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {w_ext, w_brk, r_byte};
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_fifo_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_fifo_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // ---------------- held key, counters, overflow ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_held_valid <= 1'b0;
         r_held_code  <= 9'd0;
         r_press_cnt  <= '0;
         r_drop_cnt   <= '0;
         r_ovf        <= 1'b0;
      end else begin
         if (w_emit && !w_brk) begin
            r_held_valid <= 1'b1;
            r_held_code  <= {w_ext, r_byte};
         end else if (w_emit && ({w_ext, r_byte} == r_held_code)) begin
            r_held_valid <= 1'b0;
         end
         if (w_push_req && !w_brk)
            r_press_cnt <= r_press_cnt + CNT_WIDTH'(1);
         if (w_drop && (r_drop_cnt != '1))
            r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
         if (ps2_overflow) r_ovf <= 1'b1;
      end
   end

   assign ev_valid   = (r_count != '0);
   assign ev_data    = r_mem[r_rd_ptr];
   assign held_valid = r_held_valid;
   assign held_code  = r_held_code;
   assign press_cnt  = r_press_cnt;
   assign drop_cnt   = r_drop_cnt;
   assign ovf_sticky = r_ovf;

endmodule
